// File: rtl/ysyx_23060201_axil_sram_if.sv
// AXI4-Lite bus bundle between the core's memory requesters and the SRAM responder.
// master drives requests and response-readys; slave drives request-readys and responses.
interface ysyx_23060201_axil_sram_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_23060201_axil_sram.sv
// AXI4-Lite responder over a word-organised SRAM with programmable response latency.
// Define YSYX_23060201_SRAM_RAND_DELAY_EN to replace LATENCY with LFSR-driven 0..7 wait cycles.
module ysyx_23060201_axil_sram #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                    LATENCY    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   ysyx_23060201_axil_sram_if.slave   bus,
   output logic [1:0]                 r_state_dbg,
   output logic [1:0]                 w_state_dbg
);

   // Handshake rule: a beat transfers on the rising edge where valid and ready are both high.
   // Readys here depend only on FSM state (never on valid); valids hold until their ready.

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * STRB_W);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && (off < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> OFF_W);
   endfunction

   // Wait-cycle count loaded into a channel counter when its request is accepted.
   logic [3:0] lat_load;

`ifdef YSYX_23060201_SRAM_RAND_DELAY_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign lat_load = {1'b0, lfsr[2:0]};
`else
   assign lat_load = 4'(LATENCY);
`endif

   // ---------------- read channel ----------------
   r_state_t              r_state, r_next;
   logic [ADDR_WIDTH-1:0] ar_addr_q;
   logic [3:0]            r_cnt;
   logic                  ar_hs, r_hs, r_capture;

   assign ar_hs     = bus.arvalid && bus.arready;
   assign r_hs      = bus.rvalid && bus.rready;
   assign r_capture = (r_state == R_WAIT) && (r_cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
      end else begin
         r_state <= r_next;
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_WAIT;
         R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
         R_RESP:  if (r_hs) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Readys are forced low while reset is held, not just after the first edge.
   always_comb begin
      bus.arready = rst_n && (r_state == R_IDLE);
      bus.rvalid  = (r_state == R_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_addr_q <= '0;
         r_cnt     <= 4'd0;
         bus.rdata <= '0;
         bus.rresp <= RESP_OKAY;
      end else begin
         if (ar_hs) begin
            ar_addr_q <= bus.araddr;
            r_cnt     <= lat_load;
         end else if ((r_state == R_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_capture) begin
            bus.rdata <= addr_ok(ar_addr_q) ? mem[addr_idx(ar_addr_q)] : '0;
            bus.rresp <= addr_ok(ar_addr_q) ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // ---------------- write channel ----------------
   w_state_t              w_state, w_next;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic [3:0]            w_cnt;
   logic                  aw_done, w_done;
   logic                  aw_hs, w_hs, b_hs, w_start, w_commit;

   assign aw_hs    = bus.awvalid && bus.awready;
   assign w_hs     = bus.wvalid && bus.wready;
   assign b_hs     = bus.bvalid && bus.bready;
   // AW and W may arrive in either order or together; start once both are held.
   assign w_start  = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
   assign w_commit = (w_state == W_WAIT) && (w_cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
      end else begin
         w_state <= w_next;
      end
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (w_start) w_next = W_WAIT;
         W_WAIT:  if (w_cnt == 4'd0) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      bus.awready = rst_n && (w_state == W_IDLE) && !aw_done;
      bus.wready  = rst_n && (w_state == W_IDLE) && !w_done;
      bus.bvalid  = (w_state == W_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         w_cnt     <= 4'd0;
         bus.bresp <= RESP_OKAY;
      end else begin
         if (aw_hs) aw_addr_q <= bus.awaddr;
         if (w_hs) begin
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
         end
         if (w_start) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_cnt   <= lat_load;
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if ((w_state == W_WAIT) && (w_cnt != 4'd0)) w_cnt <= w_cnt - 4'd1;
         end
         if (w_commit) bus.bresp <= addr_ok(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Array has no reset; a capture in the commit cycle sees the pre-write word.
   always_ff @(posedge clk) begin
      if (w_commit && addr_ok(aw_addr_q)) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_strb_q[i]) mem[addr_idx(aw_addr_q)][8*i +: 8] <= w_data_q[8*i +: 8];
         end
      end
   end

   assign r_state_dbg = r_state;
   assign w_state_dbg = w_state;

endmodule

// File: tb/tb_ysyx_23060201_axil_sram.sv
// Randomised bench for the AXI4-Lite SRAM responder against a word-array reference model.
module tb_ysyx_23060201_axil_sram;
   localparam int          LATENCY = 1;
   localparam int          DEPTH   = 1024;
   localparam int          WIN     = 16;
   localparam logic [31:0] BASE    = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  r_state_dbg, w_state_dbg;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] oob [4] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'hFFFF_FFFC, 32'h0000_0010};

   ysyx_23060201_axil_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   ysyx_23060201_axil_sram #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .r_state_dbg(r_state_dbg), .w_state_dbg(w_state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: byte-addressed window, word-granular array, byte-lane merge.
   function automatic bit ref_ok(input logic [31:0] a);
      longint unsigned x;
      x = a;
      return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + DEPTH * 4);
   endfunction

   function automatic logic [1:0] ref_write(input logic [31:0] a, input logic [31:0] d,
                                            input logic [3:0] s);
      int idx;
      if (!ref_ok(a)) return 2'b10;
      idx = int'((a - BASE) / 4);
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [33:0] ref_read(input logic [31:0] a);
      if (!ref_ok(a)) return {2'b10, 32'h0};
      return {2'b00, model[int'((a - BASE) / 4)]};
   endfunction

   task automatic check_lat(input string tag, input int lat);
`ifdef YSYX_23060201_SRAM_RAND_DELAY_EN
      check(tag, (lat >= 1 && lat <= 8), 1);
`else
      check(tag, lat, LATENCY + 1);
`endif
   endtask

   // Called on a negedge; returns on the negedge after the B handshake.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
      int cyc = 0;
      int lat = 0;
      bit aw_p = 1'b1;
      bit w_p = 1'b1;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      while ((aw_p || w_p) && cyc < 40) begin
         bus.awvalid = aw_p && (cyc >= aw_dly);
         bus.wvalid  = w_p && (cyc >= w_dly);
         if (!aw_p && w_p) check("aw_first_rdy", {bus.awready, bus.wready}, 2'b01);
         if (aw_p && !w_p) check("w_first_rdy", {bus.awready, bus.wready}, 2'b10);
         if (bus.awvalid && bus.awready) aw_p = 1'b0;
         if (bus.wvalid && bus.wready) w_p = 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check("aw_w_accept", {aw_p, w_p}, 2'b00);
      while (!bus.bvalid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_lat("b_latency", lat);
      resp = bus.bresp;
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      check("b_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
   endtask

   // Holds rready low for 'hold' cycles while pushing a competing arvalid.
   task automatic axi_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
      int cyc = 0;
      int lat = 0;
      bit ar_p = 1'b1;
      bus.araddr = addr;
      while (ar_p && cyc < 40) begin
         bus.arvalid = 1'b1;
         if (bus.arready) ar_p = 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.arvalid = 1'b0;
      check("ar_accept", ar_p, 0);
      while (!bus.rvalid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_lat("r_latency", lat);
      data = bus.rdata;
      resp = bus.rresp;
      for (int i = 0; i < hold; i++) begin
         bus.arvalid = 1'b1;
         bus.araddr  = ~addr;
         check("r_hold_data", bus.rdata, data);
         check("r_hold_ctl", {bus.rvalid, bus.arready, bus.rresp}, {2'b10, resp});
         @(negedge clk);
      end
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready  = 1'b0;
      bus.arvalid = 1'b0;
      check("r_done", {bus.rvalid, bus.arready}, 2'b01);
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int aw_dly, input int w_dly);
      logic [1:0] resp;
      logic [1:0] exp;
      exp = ref_write(a, d, s);
      axi_write(a, d, s, aw_dly, w_dly, resp);
      check(tag, resp, exp);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input int hold);
      logic [31:0] d;
      logic [1:0]  resp;
      logic [33:0] exp;
      exp = ref_read(a);
      axi_read(a, hold, d, resp);
      check({tag, "_data"}, d, exp[31:0]);
      check({tag, "_resp"}, resp, exp[33:32]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      logic [1:0]  resp;
      int          op;

      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", {bus.arready, bus.awready, bus.wready}, 3'b000);
      check("rst_valid", {bus.rvalid, bus.bvalid}, 2'b00);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_resp", {bus.rresp, bus.bresp}, 4'h0);
      rst_n = 1'b1;
      #1;
      check("rel_ready", {bus.arready, bus.awready, bus.wready}, 3'b111);
      @(negedge clk);

      // Basic write then read of the same word, AW and W together.
      wr_chk("wr_basic_resp", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
      axi_read(BASE + 32'h10, 0, d, resp);
      check("rd_basic_data", d, 32'hDEAD_BEEF);
      check("rd_basic_resp", resp, 2'b00);

      // Initialise the test window so every later read has a known value.
      for (int i = 0; i < WIN; i++) wr_chk("init_resp", BASE + 32'(4 * i), $urandom, 4'hF, 0, 0);

      // Byte strobes on lanes 0 and 2 only.
      wr_chk("strb_pre_resp", BASE + 32'h10, 32'h1122_3344, 4'hF, 0, 0);
      wr_chk("strb_resp", BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, 0, 0);
      axi_read(BASE + 32'h10, 0, d, resp);
      check("strb_data", d, 32'h11BB_33DD);

      // AW three cycles before W, then W before AW.
      wr_chk("skew_aw_resp", BASE + 32'h14, $urandom, 4'hF, 0, 3);
      rd_chk("skew_aw_rd", BASE + 32'h14, 0);
      wr_chk("skew_w_resp", BASE + 32'h18, $urandom, 4'hF, 2, 0);
      rd_chk("skew_w_rd", BASE + 32'h18, 0);

      // Read backpressure for five cycles.
      rd_chk("bp", BASE + 32'h10, 5);

      // Out-of-range accesses; the wrapped index must not alias word 0.
      axi_read(32'h7FFF_FFFC, 0, d, resp);
      check("oob_rd_data", d, 32'h0);
      check("oob_rd_resp", resp, 2'b10);
      wr_chk("oob_wr_resp", 32'h8000_1000, 32'h5555_AAAA, 4'hF, 0, 0);
      rd_chk("oob_alias", BASE, 0);

      // Reset while the write is waiting: no commit, no response.
      bus.awaddr = BASE + 32'h8; bus.wdata = ~model[2]; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstw_bvalid", bus.bvalid, 0);
      check("rstw_ready", {bus.arready, bus.awready, bus.wready}, 3'b000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rstw_rel_ready", {bus.arready, bus.awready, bus.wready}, 3'b111);
      @(negedge clk);
      rd_chk("rstw_keep", BASE + 32'h8, 0);

      // Reset while a read response is pending drops rvalid and rdata at once.
      bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
      @(negedge clk);
      bus.arvalid = 1'b0;
      repeat (LATENCY + 1) @(negedge clk);
      check("rstr_pre_rvalid", bus.rvalid, 1);
      rst_n = 1'b0;
      #1;
      check("rstr_rvalid", bus.rvalid, 0);
      check("rstr_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomised mix of in-window, unaligned and out-of-range traffic.
      for (int k = 0; k < 80; k++) begin
         op = $urandom_range(0, 3);
         a = BASE + 32'(4 * $urandom_range(0, WIN - 1)) + 32'($urandom_range(0, 3));
         if (op == 3) a = oob[$urandom_range(0, 3)];
         if (op == 0 || (op == 3 && $urandom_range(0, 1) == 1))
            wr_chk("rand_wr_resp", a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
         else
            rd_chk("rand_rd", a, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
